// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } boot_state_t;

  localparam int WORD_BYTES            = 4;
  localparam int DEFAULT_DEPTH         = 128;
  localparam int DEFAULT_SETTLE_CYCLES = 2;
  localparam int DEFAULT_RUN_CYCLES    = 560;

endpackage

// File: rtl/imem_boot_loader_boot_cycle_timer.sv
// Loadable down-counter with a zero flag, shared by the SETTLE and RUN budgets.
module boot_cycle_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [31:0] count;

  // Load wins over decrement; decrement parks at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams instruction words into instruction memory, then runs the CPU for a
// bounded number of cycles and raises a done flag.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int ADDR_W        = 32,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int RUN_CYCLES    = DEFAULT_RUN_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  input  logic [31:0]       s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_start_o,
  output logic [31:0]       run_cnt_o,
  output logic              done_o,
  output logic              ovf_err_o
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [31:0]     SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]     RUN_LOAD    = (RUN_CYCLES > 0) ? 32'(RUN_CYCLES - 1) : 32'd0;
  localparam bit              RUN_FOREVER = (RUN_CYCLES == 0);

  boot_state_t       state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              ready_next, start_next, done_next, ovf_next, we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       wdata_next, run_cnt_next;
  logic              accept, final_beat;
  logic              timer_load, timer_dec, timer_zero;
  logic [31:0]       timer_val;

  assign accept     = s_valid_i & s_ready_o;
  assign final_beat = accept & (s_last_i | (idx == LAST_IDX));

  boot_cycle_timer u_timer (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Next-state and next-output logic; every registered output is computed here
  // so the outputs themselves come straight from flops.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    ready_next   = 1'b0;
    start_next   = 1'b0;
    done_next    = 1'b0;
    ovf_next     = ovf_err_o;
    we_next      = 1'b0;
    addr_next    = imem_addr_o;
    wdata_next   = imem_wdata_o;
    run_cnt_next = run_cnt_o;
    timer_load   = 1'b0;
    timer_val    = 32'd0;
    timer_dec    = 1'b0;
    unique case (state)
      LOAD: begin
        ready_next = 1'b1;
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
          wdata_next = s_data_i;
          idx_next   = idx + IDX_W'(1);
          if (final_beat) begin
            state_next = SETTLE;
            ready_next = 1'b0;
            timer_load = 1'b1;
            timer_val  = SETTLE_LOAD;
            if (!s_last_i) begin
              ovf_next = 1'b1;
            end
          end
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_next = RUN;
          start_next = 1'b1;
          timer_load = !RUN_FOREVER;
          timer_val  = RUN_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      RUN: begin
        start_next = 1'b1;
        if (run_cnt_o != 32'hFFFF_FFFF) begin
          run_cnt_next = run_cnt_o + 32'd1;
        end
        if (!RUN_FOREVER) begin
          if (timer_zero) begin
            state_next = DONE;
            start_next = 1'b0;
            done_next  = 1'b1;
          end else begin
            timer_dec = 1'b1;
          end
        end
      end
      DONE: begin
        done_next = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the CPU back into reset at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= LOAD;
      idx          <= '0;
      s_ready_o    <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_start_o  <= 1'b0;
      run_cnt_o    <= '0;
      done_o       <= 1'b0;
      ovf_err_o    <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      s_ready_o    <= ready_next;
      imem_we_o    <= we_next;
      imem_addr_o  <= addr_next;
      imem_wdata_o <= wdata_next;
      cpu_start_o  <= start_next;
      run_cnt_o    <= run_cnt_next;
      done_o       <= done_next;
      ovf_err_o    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: three instances (default, shallow, run-forever)
// checked against timing and write expectations derived from the loader rules.
module tb_imem_boot_loader;

  localparam int SETTLE_C[3] = '{2, 2, 3};
  localparam int RUN_C[3]    = '{560, 20, 0};
  localparam int DEPTH_C[3]  = '{128, 4, 8};

  logic             clk;
  logic [2:0]       rst_n, valid, last;
  logic [2:0]       ready, we, start, done, ovf;
  logic [2:0][31:0] data, addr, wdata, run_cnt;

  int checks, errors;
  int sel, cyc, rise_cyc, fall_cyc;
  bit prev_start;
  logic [31:0] prog[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  imem_boot_loader #(.DEPTH(128), .ADDR_W(32), .SETTLE_CYCLES(2), .RUN_CYCLES(560)) dut_main (
    .clk_i(clk), .rst_i(rst_n[0]), .s_valid_i(valid[0]), .s_data_i(data[0]), .s_last_i(last[0]),
    .s_ready_o(ready[0]), .imem_we_o(we[0]), .imem_addr_o(addr[0]), .imem_wdata_o(wdata[0]),
    .cpu_start_o(start[0]), .run_cnt_o(run_cnt[0]), .done_o(done[0]), .ovf_err_o(ovf[0]));

  imem_boot_loader #(.DEPTH(4), .ADDR_W(32), .SETTLE_CYCLES(2), .RUN_CYCLES(20)) dut_small (
    .clk_i(clk), .rst_i(rst_n[1]), .s_valid_i(valid[1]), .s_data_i(data[1]), .s_last_i(last[1]),
    .s_ready_o(ready[1]), .imem_we_o(we[1]), .imem_addr_o(addr[1]), .imem_wdata_o(wdata[1]),
    .cpu_start_o(start[1]), .run_cnt_o(run_cnt[1]), .done_o(done[1]), .ovf_err_o(ovf[1]));

  imem_boot_loader #(.DEPTH(8), .ADDR_W(32), .SETTLE_CYCLES(3), .RUN_CYCLES(0)) dut_forever (
    .clk_i(clk), .rst_i(rst_n[2]), .s_valid_i(valid[2]), .s_data_i(data[2]), .s_last_i(last[2]),
    .s_ready_o(ready[2]), .imem_we_o(we[2]), .imem_addr_o(addr[2]), .imem_wdata_o(wdata[2]),
    .cpu_start_o(start[2]), .run_cnt_o(run_cnt[2]), .done_o(done[2]), .ovf_err_o(ovf[2]));

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Advance one clock and log what the selected instance did on that edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (we[sel]) begin
      wr_addr_q.push_back(addr[sel]);
      wr_data_q.push_back(wdata[sel]);
      wr_cyc_q.push_back(cyc);
    end
    if (start[sel] && !prev_start) rise_cyc = cyc;
    if (!start[sel] && prev_start) fall_cyc = cyc;
    prev_start = start[sel];
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rise_cyc   = -1;
    fall_cyc   = -1;
    prev_start = start[sel];
    cyc        = 0;
  endtask

  task automatic do_reset(input int d);
    sel      = d;
    valid[d] = 1'b0;
    last[d]  = 1'b0;
    rst_n[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[d] = 1'b1;
    step();
    clear_log();
  endtask

  // Offer every word of prog with optional idle gaps; count accepted beats
  task automatic load_prog(input int gap, input bit rand_gap, input bit mark_last,
                           input bit hold_valid, output int accepted);
    accepted = 0;
    for (int i = 0; i < prog.size(); i++) begin
      int g;
      int t;
      g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
      valid[sel] = 1'b0;
      repeat (g) step();
      valid[sel] = 1'b1;
      data[sel]  = prog[i];
      last[sel]  = mark_last && (i == prog.size() - 1);
      t = 0;
      while (!ready[sel] && t < 8) begin
        step();
        t++;
      end
      if (ready[sel]) begin
        step();
        accepted++;
      end
    end
    valid[sel] = hold_valid;
    data[sel]  = $urandom;
    last[sel]  = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int t;
    t = 0;
    while (!done[sel] && t < budget) begin
      step();
      t++;
    end
    checks++;
    if (done[sel] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done_wait: done=%0b after %0d cycles, expected 1", tag, done[sel], t);
    end
  endtask

  // Writes must land at word addresses 0,4,8,... carrying the program words in order
  task automatic check_program(input string tag, input int n, input bit consecutive);
    checks++;
    if (wr_addr_q.size() != n) begin
      errors++;
      $display("[TB] FAIL %s_write_count: got %0d writes, expected %0d", tag, wr_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 32'(i * 4)) begin
        errors++;
        $display("[TB] FAIL %s_addr[%0d]: got %0h expected %0h", tag, i, wr_addr_q[i], i * 4);
      end
      checks++;
      if (wr_data_q[i] !== prog[i]) begin
        errors++;
        $display("[TB] FAIL %s_data[%0d]: got %08h expected %08h", tag, i, wr_data_q[i], prog[i]);
      end
      if (consecutive && i > 0) begin
        checks++;
        if (wr_cyc_q[i] != wr_cyc_q[i-1] + 1) begin
          errors++;
          $display("[TB] FAIL %s_b2b[%0d]: write gap %0d cycles, expected 1", tag, i, wr_cyc_q[i] - wr_cyc_q[i-1]);
        end
      end
    end
  endtask

  // Start rises SETTLE cycles after the final write and stays up RUN cycles
  task automatic check_run_timing(input string tag);
    int last_wr;
    last_wr = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size()-1] : -1000;
    checks++;
    if (rise_cyc != last_wr + SETTLE_C[sel]) begin
      errors++;
      $display("[TB] FAIL %s_start_delay: rise at %0d, expected %0d", tag, rise_cyc, last_wr + SETTLE_C[sel]);
    end
    checks++;
    if (fall_cyc - rise_cyc != RUN_C[sel]) begin
      errors++;
      $display("[TB] FAIL %s_run_len: start high %0d cycles, expected %0d", tag, fall_cyc - rise_cyc, RUN_C[sel]);
    end
    checks++;
    if (run_cnt[sel] !== 32'(RUN_C[sel])) begin
      errors++;
      $display("[TB] FAIL %s_run_cnt: got %0d expected %0d", tag, run_cnt[sel], RUN_C[sel]);
    end
    checks++;
    if ({start[sel], ready[sel]} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL %s_done_outputs: start/ready=%b expected 00", tag, {start[sel], ready[sel]});
    end
  endtask

  task automatic load_spec_words();
    prog.delete();
    prog.push_back(32'h2008_0005);
    prog.push_back(32'h2009_0003);
    prog.push_back(32'h0109_5020);
    prog.push_back(32'hAC0A_0000);
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n[0] = 1'b0;
    #3;
    checks++;
    if ({ready[0], we[0], start[0], done[0], ovf[0]} !== 5'b0 || run_cnt[0] !== 32'd0 ||
        addr[0] !== 32'd0 || wdata[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rdy/we/st/dn/ovf=%b cnt=%0h addr=%0h wd=%0h, expected all 0",
               {ready[0], we[0], start[0], done[0], ovf[0]}, run_cnt[0], addr[0], wdata[0]);
    end
    @(posedge clk);
    #1 rst_n[0] = 1'b1;
    #2;
    checks++;
    if (ready[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready_before_edge: got %0b expected 0", ready[0]);
    end
    step();
    checks++;
    if (ready[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_after_edge: got %0b expected 1", ready[0]);
    end
  endtask

  task automatic test_basic_load();
    int acc;
    do_reset(0);
    load_spec_words();
    load_prog(0, 1'b0, 1'b1, 1'b0, acc);
    checks++;
    if (acc != 4) begin
      errors++;
      $display("[TB] FAIL basic_accepted: got %0d expected 4", acc);
    end
    run_to_done("basic", 2000);
    check_program("basic", 4, 1'b1);
    check_run_timing("basic");
  endtask

  task automatic test_valid_gaps();
    int acc;
    do_reset(0);
    load_spec_words();
    load_prog(3, 1'b0, 1'b1, 1'b0, acc);
    run_to_done("gaps", 2000);
    check_program("gaps", 4, 1'b0);
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      checks++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) begin
        errors++;
        $display("[TB] FAIL gaps_spacing[%0d]: got %0d cycles expected 4", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    check_run_timing("gaps");
  endtask

  task automatic test_random_programs();
    int acc, n;
    for (int it = 0; it < 3; it++) begin
      do_reset(0);
      n = int'($urandom_range(12, 1));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load_prog(2, 1'b1, 1'b1, 1'b0, acc);
      run_to_done("random", 2000);
      check_program("random", n, 1'b0);
      check_run_timing("random");
    end
  endtask

  task automatic test_hold_valid();
    int acc;
    do_reset(0);
    load_spec_words();
    load_prog(0, 1'b0, 1'b1, 1'b1, acc);
    run_to_done("hold", 2000);
    repeat (5) step();
    valid[0] = 1'b0;
    check_program("hold", 4, 1'b1);
    checks++;
    if (done[0] !== 1'b1 || run_cnt[0] !== 32'd560) begin
      errors++;
      $display("[TB] FAIL hold_done_stable: done=%0b cnt=%0d expected 1/560", done[0], run_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int acc, t;
    do_reset(0);
    load_spec_words();
    load_prog(0, 1'b0, 1'b1, 1'b0, acc);
    t = 0;
    while (!start[0] && t < 20) begin
      step();
      t++;
    end
    repeat (100) step();
    checks++;
    if (start[0] !== 1'b1 || run_cnt[0] !== 32'd100) begin
      errors++;
      $display("[TB] FAIL midrun_pre: start=%0b cnt=%0d expected 1/100", start[0], run_cnt[0]);
    end
    #2 rst_n[0] = 1'b0;
    #1;
    checks++;
    if ({start[0], done[0], ready[0], we[0]} !== 4'b0 || run_cnt[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrun_async: st/dn/rdy/we=%b cnt=%0d expected 0000/0",
               {start[0], done[0], ready[0], we[0]}, run_cnt[0]);
    end
    do_reset(0);
    prog.delete();
    prog.push_back($urandom);
    load_prog(0, 1'b0, 1'b1, 1'b0, acc);
    repeat (3) step();
    check_program("reload", 1, 1'b0);
  endtask

  task automatic test_overflow();
    int acc;
    do_reset(1);
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back($urandom);
    load_prog(0, 1'b0, 1'b0, 1'b0, acc);
    checks++;
    if (acc != DEPTH_C[1]) begin
      errors++;
      $display("[TB] FAIL ovf_accepted: got %0d expected %0d", acc, DEPTH_C[1]);
    end
    checks++;
    if (ovf[1] !== 1'b1 || ready[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_flag: ovf=%0b ready=%0b expected 1/0", ovf[1], ready[1]);
    end
    run_to_done("ovf", 200);
    check_program("ovf", DEPTH_C[1], 1'b1);
    check_run_timing("ovf");
  endtask

  task automatic test_last_at_depth();
    int acc;
    do_reset(1);
    prog.delete();
    for (int i = 0; i < DEPTH_C[1]; i++) prog.push_back($urandom);
    load_prog(0, 1'b0, 1'b1, 1'b0, acc);
    run_to_done("full", 200);
    check_program("full", DEPTH_C[1], 1'b1);
    checks++;
    if (ovf[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_no_ovf: ovf=%0b expected 0", ovf[1]);
    end
  endtask

  task automatic test_run_forever();
    int acc, t, drops;
    do_reset(2);
    prog.delete();
    prog.push_back($urandom);
    load_prog(0, 1'b0, 1'b1, 1'b0, acc);
    t = 0;
    while (!start[2] && t < 20) begin
      step();
      t++;
    end
    check_program("forever", 1, 1'b0);
    checks++;
    if (wr_cyc_q.size() == 0 || rise_cyc != wr_cyc_q[0] + SETTLE_C[2]) begin
      errors++;
      $display("[TB] FAIL forever_start_delay: rise at %0d, expected settle %0d after write", rise_cyc, SETTLE_C[2]);
    end
    drops = 0;
    repeat (10000) begin
      step();
      if (start[2] !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0 || done[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL forever_run: start low %0d cycles, done=%0b, expected 0/0", drops, done[2]);
    end
    checks++;
    if (run_cnt[2] !== 32'd10000) begin
      errors++;
      $display("[TB] FAIL forever_run_cnt: got %0d expected 10000", run_cnt[2]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    sel        = 0;
    cyc        = 0;
    prev_start = 1'b0;
    rise_cyc   = -1;
    fall_cyc   = -1;
    rst_n      = '0;
    valid      = '0;
    last       = '0;
    data       = '0;
    repeat (2) @(posedge clk);
    #1 rst_n[2:1] = 2'b11;
    test_reset();
    test_basic_load();
    test_valid_gaps();
    test_random_programs();
    test_hold_valid();
    test_reset_mid_run();
    test_overflow();
    test_last_at_depth();
    test_run_forever();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream boot stage for Simple_Single_CPU.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into the instruction memory write port.
- After loading, releases the CPU start/reset line and bounds execution to a fixed cycle budget.
- Lets a bench or host load a program, run it for N cycles, then read a done flag. This replaces hard-coded preload files and fixed `$finish` delays.

Parameters:
- DEPTH, 128, instruction memory depth in 32-bit words (power of two, ≥2).
- ADDR_W, 32, width of the byte address driven to instruction memory.
- SETTLE_CYCLES, 2, cycles between the final write and the start assertion (≥1).
- RUN_CYCLES, 560, cycles to hold the CPU started; 0 = run indefinitely.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- s_valid_i  in  1  loader word valid
- s_data_i  in  32  instruction word
- s_last_i  in  1  marks final word of program
- s_ready_o  out  1  loader can accept a word
- imem_we_o  out  1  instruction memory write enable
- imem_addr_o  out  ADDR_W  byte address of write (word aligned, low 2 bits 0)
- imem_wdata_o  out  32  write data
- cpu_start_o  out  1  drives CPU active-low reset/start (1 = CPU running)
- run_cnt_o  out  32  cycles spent in RUN, saturating at 0xFFFFFFFF
- done_o  out  1  RUN budget exhausted
- ovf_err_o  out  1  sticky: DEPTH words accepted without s_last_i

Behaviour:
- Reset (async, rst_i=0) drives every output to 0 immediately and sets state to LOAD with word index 0.
- Reset does not clear instruction memory contents.
- Reset release is synchronous to clk_i: s_ready_o rises on the first edge after release.
- States and transitions:
  - LOAD: s_ready_o=1. A beat is accepted when s_valid_i & s_ready_o at a rising edge. On the last accepted beat (s_last_i=1, or index==DEPTH-1), go to SETTLE.
  - SETTLE: s_ready_o=0, cpu_start_o=0. Count SETTLE_CYCLES cycles, then go to RUN.
  - RUN: cpu_start_o=1, and run_cnt_o increments every cycle. Go to DONE when run_cnt_o reaches RUN_CYCLES; RUN_CYCLES=0 never leaves RUN.
  - DONE: cpu_start_o=0, done_o=1, s_ready_o=0. Terminal until reset; run_cnt_o holds its final value.
- Write latency is 1 cycle. On the edge accepting a beat, the following are registered:
  - imem_we_o=1
  - imem_addr_o = index*4
  - imem_wdata_o = s_data_i
- imem_we_o is 0 in every cycle without an accepted beat. Address and data hold their last values.
- Back-to-back beats give back-to-back writes at consecutive addresses. Valid gaps insert we=0 cycles with no address advance.
- Index wraps by leaving LOAD, never by address wrap: the highest address written is (DEPTH-1)*4.
- Overflow: if beat DEPTH-1 is accepted with s_last_i=0, set ovf_err_o and proceed to SETTLE anyway. Later words are never accepted (ready=0).
- s_last_i on the index-DEPTH-1 beat: no error.
- s_valid_i during SETTLE/RUN/DONE is ignored and no write occurs.
- The SETTLE count starts on the edge after the final write, so the final imem write is always visible before cpu_start_o rises.
- cpu_start_o is a registered output, glitch-free. It asserts exactly SETTLE_CYCLES cycles after the final imem_we_o pulse. It is high for exactly RUN_CYCLES cycles (RUN_CYCLES≠0).
- Reset mid-operation (any state): outputs drop to 0 asynchronously, including cpu_start_o, so the CPU is held in reset. Loading restarts at address 0.

Decomposition:
- Package imem_boot_pkg holds:
  - state enum {LOAD, SETTLE, RUN, DONE}, 2-bit encoding
  - WORD_BYTES=4
  - default constants for DEPTH, SETTLE_CYCLES, RUN_CYCLES
- One sub-module, boot_cycle_timer: loadable down-counter with a zero flag, used for both SETTLE and RUN budgets. run_cnt_o remains a separate saturating up-counter in the top.

Test Plan:
- Load 4 words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000, with s_last_i on word 4 -> writes at addresses 0, 4, 8, 12 with matching data on consecutive cycles. cpu_start_o rises 2 cycles after the last write and stays high 560 cycles, then done_o=1 and run_cnt_o=560.
- Same 4 words with s_valid_i low 3 cycles between each beat -> exactly 4 we pulses at 0, 4, 8, 12 and no writes during gaps. Start timing is relative to the final write.
- DEPTH=4, stream 6 words with no s_last_i -> 4 writes (0..12), ovf_err_o=1, s_ready_o=0 from word 5 on, and no 5th write.
- Drop rst_i low 100 cycles into RUN -> cpu_start_o, done_o, and run_cnt_o go 0 asynchronously. After release, reload 1 word -> write at address 0.
- RUN_CYCLES=0, load 1 word with last -> cpu_start_o stays high for 10000 cycles, done_o stays 0, and run_cnt_o=10000.
- Hold s_valid_i=1 through SETTLE and DONE -> no imem_we_o pulses after the final load beat.
